// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - load/store initiator serializing accesses onto a byte-wide memory port
//
// Accepts one load/store at a time from the MEM stage, walks the bytes of the
// access most-significant first on an 8-bit memory port, and returns a single
// cycle response. Misaligned and illegal-size requests are trapped at
// acceptance and never touch memory.
//
// Ports:
//   clk, reset_n          clock (rising edge), synchronous active-low reset
//   req_valid/req_ready   request handshake; ready only while IDLE
//   req_write, req_size   store/load, 00 byte / 01 half / 10 word / 11 illegal
//   req_sign              loads: sign-extend (1) or zero-extend (0)
//   req_addr, req_wdata   address of the most-significant byte, right-aligned store data
//   resp_valid            one-cycle response strobe (no backpressure)
//   resp_rdata            extended load data; 0 for stores and errors
//   resp_error            misaligned or illegal size, qualified by resp_valid
//   mem_en, mem_we        byte access enable / write select
//   mem_addr, mem_wdata   byte address and write byte
//   mem_rdata             read byte, combinational from mem_addr
module mem_access_ctrl #(
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_sign,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_error,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_XFER = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t              state_q;
  logic                write_q;
  logic                sign_q;
  logic [1:0]          last_q;      // index of the final byte (n-1)
  logic [1:0]          k_q;         // index of the byte currently on the port
  logic [23:0]         data_q;      // load bytes gathered so far
  logic [31:0]         wsh_q;       // store bytes still to send, next one in [31:24]
  logic                resp_valid_q;
  logic                resp_error_q;
  logic [31:0]         resp_rdata_q;
  logic                mem_en_q;
  logic                mem_we_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [7:0]          mem_wdata_q;

  logic                req_err_d;
  logic [1:0]          last_d;
  logic [31:0]         aligned_d;
  logic [31:0]         asm_d;
  logic [31:0]         ext_d;

  // Alignment/size trap evaluated on the raw request at acceptance.
  always_comb begin
    req_err_d = 1'b0;
    case (req_size)
      2'b00:   req_err_d = 1'b0;
      2'b01:   req_err_d = req_addr[0];
      2'b10:   req_err_d = (req_addr[1:0] != 2'b00);
      default: req_err_d = 1'b1;
    endcase
  end

  // Left-justify store data so the big-endian byte order becomes a plain
  // shift out of the top byte. Loads carry no write data.
  always_comb begin
    last_d    = 2'd0;
    aligned_d = 32'h0;
    case (req_size)
      2'b01: begin
        last_d    = 2'd1;
        aligned_d = {req_wdata[15:0], 16'h0};
      end
      2'b10: begin
        last_d    = 2'd3;
        aligned_d = req_wdata;
      end
      default: begin
        last_d    = 2'd0;
        aligned_d = {req_wdata[7:0], 24'h0};
      end
    endcase
    if (!req_write) aligned_d = 32'h0;
  end

  // Assembled load value including the byte on the port this cycle, then
  // extended from bit 8n-1.
  always_comb begin
    asm_d = {data_q, mem_rdata};
    ext_d = asm_d;
    case (last_q)
      2'd0:    ext_d = {{24{sign_q & asm_d[7]}}, asm_d[7:0]};
      2'd1:    ext_d = {{16{sign_q & asm_d[15]}}, asm_d[15:0]};
      default: ext_d = asm_d;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      write_q      <= 1'b0;
      sign_q       <= 1'b0;
      last_q       <= 2'd0;
      k_q          <= 2'd0;
      data_q       <= 24'h0;
      wsh_q        <= 32'h0;
      resp_valid_q <= 1'b0;
      resp_error_q <= 1'b0;
      resp_rdata_q <= 32'h0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= 8'h0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            write_q <= req_write;
            sign_q  <= req_sign;
            last_q  <= last_d;
            k_q     <= 2'd0;
            data_q  <= 24'h0;
            if (req_err_d) begin
              state_q      <= S_RESP;
              resp_valid_q <= 1'b1;
              resp_error_q <= 1'b1;
              resp_rdata_q <= 32'h0;
            end else begin
              state_q     <= S_XFER;
              mem_en_q    <= 1'b1;
              mem_we_q    <= req_write;
              mem_addr_q  <= req_addr;
              mem_wdata_q <= aligned_d[31:24];
              wsh_q       <= {aligned_d[23:0], 8'h0};
            end
          end
        end
        S_XFER: begin
          data_q <= asm_d[23:0];
          if (k_q == last_q) begin
            state_q      <= S_RESP;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_wdata_q  <= 8'h0;
            resp_valid_q <= 1'b1;
            resp_error_q <= 1'b0;
            resp_rdata_q <= write_q ? 32'h0 : ext_d;
          end else begin
            k_q         <= k_q + 2'd1;
            mem_addr_q  <= mem_addr_q + ADDR_W'(1);
            mem_wdata_q <= wsh_q[31:24];
            wsh_q       <= {wsh_q[23:0], 8'h0};
          end
        end
        default: begin
          state_q      <= S_IDLE;
          resp_valid_q <= 1'b0;
          resp_error_q <= 1'b0;
          resp_rdata_q <= 32'h0;
        end
      endcase
    end
  end

  assign req_ready  = (state_q == S_IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_error = resp_error_q;
  assign resp_rdata = resp_rdata_q;
  assign mem_en     = mem_en_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - directed self-checking bench for mem_access_ctrl
module tb_mem_access_ctrl;

  localparam int ADDR_W = 9;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [1:0]        req_size;
  logic              req_sign;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_error;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata;

  int total = 0;
  int bad   = 0;

  logic [7:0] mem [0:511];
  logic       mem_clr;
  int         en_cnt = 0;

  mem_access_ctrl #(.ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_size   (req_size),
    .req_sign   (req_sign),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_error (resp_error),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  // Byte memory: combinational read, write on the edge ending an enabled cycle.
  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 512; i++) mem[i] <= 8'h00;
    end else if (mem_en && mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
    if (mem_en) en_cnt <= en_cnt + 1;
  end

  task automatic set_req(input logic wr, input logic [1:0] sz, input logic sg,
                         input logic [ADDR_W-1:0] ad, input logic [31:0] wd);
    req_valid = 1'b1;
    req_write = wr;
    req_size  = sz;
    req_sign  = sg;
    req_addr  = ad;
    req_wdata = wd;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    mem_clr = 1'b1;
    set_req(1'b1, 2'b10, 1'b0, 9'h010, 32'hCAFEF00D);
    for (int e = 0; e < 2; e++) begin
      @(posedge clk);
      @(negedge clk);
      total++;
      if ({resp_valid, resp_error, mem_en, mem_we} !== 4'b0000) begin
        bad++;
        $display("FAIL reset_ctrl[%0d]: got rv/re/en/we=%b want 0000", e,
                 {resp_valid, resp_error, mem_en, mem_we});
      end
      total++;
      if (resp_rdata !== 32'h0 || mem_addr !== 9'h0 || mem_wdata !== 8'h0) begin
        bad++;
        $display("FAIL reset_data[%0d]: got rdata=%h addr=%h wdata=%h want 0", e,
                 resp_rdata, mem_addr, mem_wdata);
      end
    end
    req_valid = 1'b0;
    reset_n   = 1'b1;
    mem_clr   = 1'b0;
    @(negedge clk);
    total++;
    if (req_ready !== 1'b1 || en_cnt !== 0) begin
      bad++;
      $display("FAIL reset_ready: got ready=%b en_cnt=%0d want ready=1 en_cnt=0",
               req_ready, en_cnt);
    end
  endtask

  task automatic test_word_store();
    logic [7:0] exp_b [4];
    exp_b[0] = 8'hDE; exp_b[1] = 8'hAD; exp_b[2] = 8'hBE; exp_b[3] = 8'hEF;
    set_req(1'b1, 2'b10, 1'b0, 9'h010, 32'hDEADBEEF);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 9'(9'h010 + i) ||
          mem_wdata !== exp_b[i]) begin
        bad++;
        $display("FAIL store_byte[%0d]: got en=%b we=%b addr=%h wdata=%h want 1 1 %h %h",
                 i, mem_en, mem_we, mem_addr, mem_wdata, 9'(9'h010 + i), exp_b[i]);
      end
      total++;
      if (req_ready !== 1'b0 || resp_valid !== 1'b0) begin
        bad++;
        $display("FAIL store_busy[%0d]: got ready=%b rv=%b want 0 0", i, req_ready, resp_valid);
      end
      @(negedge clk);
    end
    total++;
    if (resp_valid !== 1'b1 || resp_error !== 1'b0 || resp_rdata !== 32'h0 ||
        req_ready !== 1'b0 || mem_en !== 1'b0) begin
      bad++;
      $display("FAIL store_resp: got rv=%b re=%b rdata=%h ready=%b en=%b want 1 0 0 0 0",
               resp_valid, resp_error, resp_rdata, req_ready, mem_en);
    end
    @(negedge clk);
    total++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1 ||
        {mem[16], mem[17], mem[18], mem[19]} !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL store_mem: got rv=%b ready=%b mem=%h want 0 1 deadbeef", resp_valid,
               req_ready, {mem[16], mem[17], mem[18], mem[19]});
    end
  endtask

  task automatic test_load(input string name, input logic [1:0] sz, input logic sg,
                           input logic [ADDR_W-1:0] ad, input int n,
                           input logic [31:0] exp_data);
    set_req(1'b0, sz, sg, ad, 32'hFFFFFFFF);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      total++;
      if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 9'(ad + i) ||
          req_ready !== 1'b0 || resp_valid !== 1'b0) begin
        bad++;
        $display("FAIL %s_xfer[%0d]: got en=%b we=%b addr=%h ready=%b rv=%b want 1 0 %h 0 0",
                 name, i, mem_en, mem_we, mem_addr, req_ready, resp_valid, 9'(ad + i));
      end
      @(negedge clk);
    end
    total++;
    if (resp_valid !== 1'b1 || resp_error !== 1'b0 || resp_rdata !== exp_data ||
        mem_en !== 1'b0) begin
      bad++;
      $display("FAIL %s_resp: got rv=%b re=%b rdata=%h en=%b want 1 0 %h 0",
               name, resp_valid, resp_error, resp_rdata, mem_en, exp_data);
    end
    @(negedge clk);
  endtask

  task automatic test_error(input string name, input logic [1:0] sz,
                            input logic [ADDR_W-1:0] ad);
    int cnt0;
    cnt0 = en_cnt;
    set_req(1'b1, sz, 1'b0, ad, 32'h12345678);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    total++;
    if (resp_valid !== 1'b1 || resp_error !== 1'b1 || resp_rdata !== 32'h0 ||
        mem_en !== 1'b0) begin
      bad++;
      $display("FAIL %s_resp: got rv=%b re=%b rdata=%h en=%b want 1 1 0 0",
               name, resp_valid, resp_error, resp_rdata, mem_en);
    end
    @(negedge clk);
    total++;
    if (en_cnt !== cnt0 || req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      bad++;
      $display("FAIL %s_after: got en_pulses=%0d ready=%b rv=%b want 0 1 0",
               name, en_cnt - cnt0, req_ready, resp_valid);
    end
  endtask

  task automatic test_reset_mid_op();
    set_req(1'b1, 2'b10, 1'b0, 9'h020, 32'h11223344);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    total++;
    if (mem_en !== 1'b1 || mem_addr !== 9'h022) begin
      bad++;
      $display("FAIL midrst_t3: got en=%b addr=%h want 1 022", mem_en, mem_addr);
    end
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (mem_en !== 1'b0 || resp_valid !== 1'b0) begin
        bad++;
        $display("FAIL midrst_quiet[%0d]: got en=%b rv=%b want 0 0", i, mem_en, resp_valid);
      end
      @(negedge clk);
    end
    total++;
    if (mem[32] !== 8'h11 || mem[33] !== 8'h22 || mem[35] !== 8'h00 || req_ready !== 1'b1) begin
      bad++;
      $display("FAIL midrst_mem: got %h %h %h ready=%b want 11 22 00 1",
               mem[32], mem[33], mem[35], req_ready);
    end
  endtask

  task automatic test_back_to_back();
    set_req(1'b0, 2'b10, 1'b0, 9'h010, 32'h0);
    @(posedge clk);
    @(negedge clk);
    // Second request held valid for the whole load.
    set_req(1'b1, 2'b00, 1'b0, 9'h1FF, 32'h0000005A);
    for (int i = 0; i < 4; i++) begin
      total++;
      if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 9'(9'h010 + i) ||
          req_ready !== 1'b0) begin
        bad++;
        $display("FAIL b2b_load[%0d]: got en=%b we=%b addr=%h ready=%b want 1 0 %h 0",
                 i, mem_en, mem_we, mem_addr, req_ready, 9'(9'h010 + i));
      end
      @(negedge clk);
    end
    total++;
    if (resp_valid !== 1'b1 || resp_rdata !== 32'hDEADBEEF || req_ready !== 1'b0 ||
        mem_en !== 1'b0) begin
      bad++;
      $display("FAIL b2b_resp: got rv=%b rdata=%h ready=%b en=%b want 1 deadbeef 0 0",
               resp_valid, resp_rdata, req_ready, mem_en);
    end
    @(negedge clk);
    total++;
    if (req_ready !== 1'b1 || mem_en !== 1'b0 || resp_valid !== 1'b0) begin
      bad++;
      $display("FAIL b2b_idle: got ready=%b en=%b rv=%b want 1 0 0", req_ready, mem_en, resp_valid);
    end
    @(negedge clk);
    req_valid = 1'b0;
    total++;
    if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 9'h1FF || mem_wdata !== 8'h5A) begin
      bad++;
      $display("FAIL b2b_store: got en=%b we=%b addr=%h wdata=%h want 1 1 1ff 5a",
               mem_en, mem_we, mem_addr, mem_wdata);
    end
    @(negedge clk);
    total++;
    if (resp_valid !== 1'b1 || resp_error !== 1'b0 || resp_rdata !== 32'h0) begin
      bad++;
      $display("FAIL b2b_sresp: got rv=%b re=%b rdata=%h want 1 0 0",
               resp_valid, resp_error, resp_rdata);
    end
    @(negedge clk);
    total++;
    if (mem[511] !== 8'h5A || req_ready !== 1'b1) begin
      bad++;
      $display("FAIL b2b_mem: got mem[1ff]=%h ready=%b want 5a 1", mem[511], req_ready);
    end
  endtask

  initial begin
    reset_n   = 1'b0;
    mem_clr   = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_size  = 2'b00;
    req_sign  = 1'b0;
    req_addr  = '0;
    req_wdata = 32'h0;
    @(negedge clk);
    test_reset();
    test_word_store();
    test_load("ld_half_s", 2'b01, 1'b1, 9'h012, 2, 32'hFFFFBEEF);
    test_load("ld_half_z", 2'b01, 1'b0, 9'h012, 2, 32'h0000BEEF);
    test_load("ld_byte_s", 2'b00, 1'b1, 9'h011, 1, 32'hFFFFFFAD);
    test_load("ld_word",   2'b10, 1'b0, 9'h010, 4, 32'hDEADBEEF);
    test_error("err_word_mis", 2'b10, 9'h011);
    test_error("err_half_mis", 2'b01, 9'h013);
    test_error("err_size11",   2'b11, 9'h000);
    test_reset_mid_op();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
